// File: rtl/label_sram_arb_pkg.sv
// Shared constants and types for the label SRAM arbiter.
package lblpkg;

   localparam int unsigned AW    = 10;
   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 1024;

   localparam logic SRAM_WEN_WRITE = 1'b0;
   localparam logic SRAM_WEN_READ  = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      SERVE,
      DRAIN,
      DONE
   } state_e;

endpackage

// File: rtl/label_sram_arb_rr_arb2.sv
// Two-requester round-robin grant; pointer moves only on contention (0 = read preferred).
module rr_arb2 (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic req_rd,
   input  logic req_wr,
   output logic gnt_rd,
   output logic gnt_wr
);

   logic ptr_q, ptr_d;

   always_comb begin
      gnt_rd = 1'b0;
      gnt_wr = 1'b0;
      ptr_d  = ptr_q;
      if (en) begin
         if (req_rd && req_wr) begin
            gnt_rd = !ptr_q;
            gnt_wr = ptr_q;
            ptr_d  = !ptr_q;
         end else begin
            gnt_rd = req_rd;
            gnt_wr = req_wr;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/label_sram_arb.sv
// Label SRAM owner: clear-on-init, round-robin read/write service, drain to finish on done.
module label_sram_arb #(
   parameter int unsigned AW    = 10,
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 1024
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          init,
   input  logic          eng_done,
   input  logic          rd_valid,
   output logic          rd_ready,
   input  logic [AW-1:0] rd_addr,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_data,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic [AW-1:0] sram_a,
   output logic [DW-1:0] sram_d,
   output logic          sram_wen,
   input  logic [DW-1:0] sram_q,
   output logic          finish
);

   import lblpkg::*;

   state_e        state_q, state_d;
   logic [AW:0]   clr_cnt_q, clr_cnt_d;
   logic          done_pend_q, done_pend_d;
   // [0]: read issued to SRAM last edge, [1]: SRAM data valid this cycle
   logic [1:0]    rd_pipe_q, rd_pipe_d;
   logic [AW-1:0] sram_a_d;
   logic [DW-1:0] sram_d_d;
   logic          sram_wen_d;
   logic          rsp_valid_d;
   logic [DW-1:0] rsp_data_d;
   logic          finish_d;
   logic          serve_en;
   logic          gnt_rd, gnt_wr;

   // A done already pending when SERVE is entered suppresses all grants in that cycle.
   assign serve_en = (state_q == SERVE) && !done_pend_q;

   rr_arb2 u_rr_arb2 (
      .clk    (clk),
      .reset  (reset),
      .en     (serve_en),
      .req_rd (rd_valid),
      .req_wr (wr_valid),
      .gnt_rd (gnt_rd),
      .gnt_wr (gnt_wr)
   );

   assign rd_ready = gnt_rd;
   assign wr_ready = gnt_wr;

   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      done_pend_d = done_pend_q;
      sram_a_d    = sram_a;
      sram_d_d    = sram_d;
      sram_wen_d  = SRAM_WEN_READ;
      finish_d    = finish;
      rd_pipe_d   = {rd_pipe_q[0], gnt_rd};
      rsp_valid_d = rd_pipe_q[1];
      rsp_data_d  = rd_pipe_q[1] ? sram_q : rsp_data;

      unique case (state_q)
         IDLE: begin
            if (eng_done) done_pend_d = 1'b1;
            if (init) state_d = CLEAR;
         end
         CLEAR: begin
            if (eng_done) done_pend_d = 1'b1;
            sram_wen_d = SRAM_WEN_WRITE;
            sram_d_d   = '0;
            sram_a_d   = clr_cnt_q[AW-1:0];
            if (clr_cnt_q == (AW+1)'(DEPTH - 1)) begin
               clr_cnt_d = '0;
               state_d   = SERVE;
            end else begin
               clr_cnt_d = clr_cnt_q + (AW+1)'(1);
            end
         end
         SERVE: begin
            if (gnt_wr) begin
               sram_a_d   = wr_addr;
               sram_d_d   = wr_data;
               sram_wen_d = SRAM_WEN_WRITE;
            end else if (gnt_rd) begin
               sram_a_d = rd_addr;
            end
            if (eng_done || done_pend_q) state_d = DRAIN;
         end
         DRAIN: begin
            if (rd_pipe_q == 2'b00) begin
               state_d  = DONE;
               finish_d = 1'b1;
            end
         end
         DONE: begin
            finish_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         clr_cnt_q   <= '0;
         done_pend_q <= 1'b0;
         rd_pipe_q   <= '0;
         sram_a      <= '0;
         sram_d      <= '0;
         sram_wen    <= SRAM_WEN_READ;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         finish      <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         done_pend_q <= done_pend_d;
         rd_pipe_q   <= rd_pipe_d;
         sram_a      <= sram_a_d;
         sram_d      <= sram_d_d;
         sram_wen    <= sram_wen_d;
         rsp_valid   <= rsp_valid_d;
         rsp_data    <= rsp_data_d;
         finish      <= finish_d;
      end
   end

endmodule

// File: tb/tb_label_sram_arb.sv
// Bench for label_sram_arb: behavioural SRAM, memory/grant scoreboard, directed plus random steps.
module tb_label_sram_arb;

   localparam int AW    = 10;
   localparam int DW    = 8;
   localparam int DEPTH = 1024;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          init = 1'b0;
   logic          eng_done = 1'b0;
   logic          rd_valid = 1'b0;
   logic          rd_ready;
   logic [AW-1:0] rd_addr = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [AW-1:0] sram_a;
   logic [DW-1:0] sram_d;
   logic          sram_wen;
   logic [DW-1:0] sram_q;
   logic          finish;

   always #5 clk = ~clk;

   label_sram_arb dut (
      .clk       (clk),
      .reset     (reset),
      .init      (init),
      .eng_done  (eng_done),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_addr   (rd_addr),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .sram_a    (sram_a),
      .sram_d    (sram_d),
      .sram_wen  (sram_wen),
      .sram_q    (sram_q),
      .finish    (finish)
   );

   // Synchronous single-port SRAM.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (sram_wen == 1'b0) mem[sram_a] <= sram_d;
      else                  sram_q      <= mem[sram_a];
   end

   typedef struct {
      int            due;
      logic [DW-1:0] d;
   } exp_t;

   int            n_tests = 0;
   int            n_fail = 0;
   int            cyc_n = 0;
   bit            m_open = 1'b0;
   bit            m_ptr = 1'b0;
   int            m_prev_kind = 3;  // 0 idle serve, 1 write, 2 read, 3 unchecked
   logic [AW-1:0] m_prev_a;
   logic [DW-1:0] m_prev_d;
   logic [DW-1:0] ref_mem [DEPTH];
   exp_t          exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check due responses and last grant's SRAM access, drive, check grants.
   task automatic cyc(input bit rv, input logic [AW-1:0] ra, input bit wv,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit ini, input bit ed);
      bit ev, egr, egw;
      @(negedge clk);
      ev = (exp_q.size() > 0) && (exp_q[0].due == cyc_n);
      check("rsp_valid", rsp_valid, ev);
      if (ev) begin
         check("rsp_data", rsp_data, exp_q[0].d);
         void'(exp_q.pop_front());
      end
      case (m_prev_kind)
         0: check("idle_wen", sram_wen, 1);
         1: begin
            check("wr_wen", sram_wen, 0);
            check("wr_a", sram_a, m_prev_a);
            check("wr_d", sram_d, m_prev_d);
         end
         2: begin
            check("rd_wen", sram_wen, 1);
            check("rd_a", sram_a, m_prev_a);
         end
         default: ;
      endcase
      rd_valid = rv; rd_addr = ra; wr_valid = wv; wr_addr = wa; wr_data = wd;
      init = ini; eng_done = ed;
      #1;
      egr = m_open && rv && (!wv || !m_ptr);
      egw = m_open && wv && (!rv || m_ptr);
      check("rd_ready", rd_ready, egr);
      check("wr_ready", wr_ready, egw);
      if (m_open && rv && wv) m_ptr = !m_ptr;
      if (egw) ref_mem[wa] = wd;
      if (egr) exp_q.push_back('{due: cyc_n + 3, d: ref_mem[ra]});
      m_prev_kind = !m_open ? 3 : egw ? 1 : egr ? 2 : 0;
      m_prev_a = egw ? wa : ra;
      m_prev_d = wd;
      if (ed) m_open = 1'b0;
      cyc_n++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, '0, 0, '0, '0, 0, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      rd_valid = 1'b1; wr_valid = 1'b1; init = 1'b0; eng_done = 1'b0;
      m_open = 1'b0; m_ptr = 1'b0; m_prev_kind = 3;
      exp_q.delete();
      @(negedge clk);
      #1;
      check("rst_sram_a", sram_a, 0);
      check("rst_sram_d", sram_d, 0);
      check("rst_sram_wen", sram_wen, 1);
      check("rst_rd_ready", rd_ready, 0);
      check("rst_wr_ready", wr_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_finish", finish, 0);
      reset = 1'b0;
   endtask

   // Init pulse then the full clear; optional eng_done pulse at clear index ed_at.
   task automatic do_clear(input int ed_at);
      int bad_wen = 0, bad_a = 0, bad_d = 0, bad_fin = 0;
      cyc(1, '0, 1, '0, '0, 1, 0);
      cyc(1, '0, 1, '0, '0, 0, 0);
      check("clr_not_started", sram_wen, 1);
      for (int i = 0; i < DEPTH; i++) begin
         if (i == DEPTH - 1 && ed_at < 0) m_open = 1'b1;
         cyc((i < DEPTH - 1) || (ed_at >= 0), '0, (i < DEPTH - 1) || (ed_at >= 0), '0, '0,
             (i == 5), (i == ed_at));
         if (sram_wen !== 1'b0) bad_wen++;
         if (sram_a !== AW'(i)) bad_a++;
         if (sram_d !== '0) bad_d++;
         if (finish !== 1'b0) bad_fin++;
      end
      check("clr_wen_cycles_bad", bad_wen, 0);
      check("clr_addr_seq_bad", bad_a, 0);
      check("clr_data_bad", bad_d, 0);
      check("clr_finish_bad", bad_fin, 0);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      do_reset();
      do_clear(-1);
      cyc(0, '0, 0, '0, '0, 0, 0);
      check("clr_exact_count", sram_wen, 1);

      // Contention from a fresh pointer: R,W,R,W,R,W
      for (int i = 0; i < 6; i++) begin
         cyc(1, AW'(i), 1, AW'(10'h300 + i), DW'(i + 1), 0, 0);
         check("contend_rd", rd_ready, (i % 2 == 0));
         check("contend_wr", wr_ready, (i % 2 == 1));
      end
      idle(4);

      // Write then read the same address
      cyc(0, '0, 1, 10'h155, 8'h07, 0, 0);
      cyc(1, 10'h155, 0, '0, '0, 0, 0);
      check("wr155_wen", sram_wen, 0);
      check("wr155_a", sram_a, 10'h155);
      cyc(0, '0, 0, '0, '0, 0, 0);
      check("rd155_wen", sram_wen, 1);
      cyc(0, '0, 0, '0, '0, 0, 0);
      check("rd155_early", rsp_valid, 0);
      cyc(0, '0, 0, '0, '0, 0, 0);
      check("rd155_valid", rsp_valid, 1);
      check("rd155_data", rsp_data, 8'h07);

      // Back-to-back reads
      cyc(0, '0, 1, 10'd3, 8'h11, 0, 0);
      cyc(0, '0, 1, 10'd4, 8'h22, 0, 0);
      cyc(0, '0, 1, 10'd5, 8'h33, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, AW'(3 + i), 0, '0, '0, 0, 0);
      for (int j = 0; j < 4; j++) begin
         cyc(0, '0, 0, '0, '0, 0, 0);
         check("b2b_valid", rsp_valid, (j < 3));
         if (j < 3) check("b2b_data", rsp_data, 8'h11 * (j + 1));
      end

      // Random traffic over a small address window for hazards
      for (int i = 0; i < 300; i++) begin
         cyc(1'($urandom), AW'($urandom_range(0, 15)), 1'($urandom),
             AW'($urandom_range(0, 15)), DW'($urandom), 0, 0);
      end
      idle(4);

      // Reset between read acceptance and its response
      cyc(1, 10'h155, 0, '0, '0, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      exp_q.delete();
      m_open = 1'b0; m_ptr = 1'b0; m_prev_kind = 3;
      check("midrst_wen", sram_wen, 1);
      check("midrst_finish", finish, 0);
      check("midrst_rd_ready", rd_ready, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("midrst_rsp", rsp_valid, 0);
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) cyc(1, '0, 1, '0, '0, 0, 0);

      // eng_done during clear: one grant-free SERVE cycle, DRAIN, then finish
      do_clear(100);
      cyc(1, '0, 1, '0, '0, 0, 0);
      check("pend_drain_wen", sram_wen, 1);
      check("pend_drain_finish", finish, 0);
      cyc(1, '0, 1, '0, '0, 0, 0);
      check("pend_finish", finish, 1);

      // Read issued together with eng_done must complete before finish
      do_reset();
      do_clear(-1);
      cyc(0, '0, 1, 10'h020, 8'h5A, 0, 0);
      cyc(1, 10'h020, 0, '0, '0, 0, 1);
      for (int i = 1; i <= 6; i++) begin
         cyc(1, AW'($urandom), 1, AW'($urandom), DW'($urandom), 1, 0);
         if (i == 3) check("drain_rsp_data", rsp_data, 8'h5A);
         check("drain_finish", finish, (i >= 4));
      end
      check("exp_q_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
